udp_tx_arbiter: RTL

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

---
 rtl/udp_tx_arbiter_pkg.sv | 27 ++
 rtl/udp_tx_arbiter_rr_arbiter4.sv | 30 +++
 rtl/udp_tx_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/udp_tx_arbiter_pkg.sv
// Shared constants for the four-channel UDP transmit arbiter.
package udp_tx_arbiter_pkg;

  localparam int CH_NUM = 4;
  localparam int LEN_W  = 16;
  localparam int DATA_W = 32;

  // FSM encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Convert a one-hot channel vector to its index (0 for an empty vector).
  function automatic logic [1:0] onehot_to_idx(input logic [CH_NUM-1:0] oh);
    logic [1:0] idx;
    case (oh)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/udp_tx_arbiter_rr_arbiter4.sv
// Combinational round-robin pick: searches upward starting one past the last
// served channel, wrapping modulo 4.
module rr_arbiter4
  import udp_tx_arbiter_pkg::*;
(
  input  logic [CH_NUM-1:0] req,
  input  logic [1:0]        last,
  output logic [CH_NUM-1:0] grant,
  output logic              valid
);

  logic [1:0] idx;

  // First requesting channel after 'last' wins; 'last' itself is checked last.
  always_comb begin
    grant = 4'b0000;
    valid = 1'b0;
    idx   = 2'd0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = last + i[1:0];
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Four-channel round-robin arbiter in front of a single UDP transmit core,
// with a watchdog that aborts a grant held too long.
module udp_tx_arbiter
  import udp_tx_arbiter_pkg::*;
#(
  parameter int          U_DLY       = 1,          // kept for interface compatibility
  parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic [3:0]    req_apply,
  input  logic [63:0]   req_data_len,
  input  logic [127:0]  req_data,
  output logic [3:0]    req_data_en,
  output logic [3:0]    req_send_over,
  output logic          udp_send_apply,
  output logic [15:0]   udp_send_data_len,
  output logic [31:0]   udp_send_data,
  input  logic          udp_send_data_en,
  input  logic          udp_send_over,
  output logic [3:0]    arb_grant,
  output logic          timeout_pulse
);

  logic [1:0]        state;
  logic [1:0]        last_grant;
  logic [15:0]       wd_cnt;
  logic [15:0]       wd_next;
  logic              wd_hit;
  logic [CH_NUM-1:0] pick_grant;
  logic              pick_valid;
  logic [LEN_W-1:0]  pick_len;
  logic              active;

  rr_arbiter4 u_rr (
    .req   (req_apply),
    .last  (last_grant),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign wd_next = wd_cnt + 16'd1;
  assign wd_hit  = (wd_next >= TIMEOUT_CYC);
  assign active  = (state == ST_APPLY) || (state == ST_SEND);

  // Length of the channel about to be granted.
  always_comb begin
    pick_len = 16'd0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (pick_grant[n]) pick_len = req_data_len[16*n +: 16];
      else               pick_len = pick_len;
    end
  end

  // Word mux for the current owner; zero when nobody owns the core.
  always_comb begin
    udp_send_data = 32'd0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (arb_grant[n]) udp_send_data = req_data[32*n +: 32];
      else              udp_send_data = udp_send_data;
    end
  end

  // Route the core's read strobe only to the owner while a frame is live.
  always_comb begin
    if (active) req_data_en = arb_grant & {4{udp_send_data_en}};
    else        req_data_en = 4'b0000;
  end

  // Grant FSM, watchdog and registered handshake outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      arb_grant         <= 4'b0000;
      last_grant        <= 2'd3;
      udp_send_apply    <= 1'b0;
      udp_send_data_len <= 16'd0;
      req_send_over     <= 4'b0000;
      timeout_pulse     <= 1'b0;
      wd_cnt            <= 16'd0;
    end else begin
      req_send_over <= 4'b0000;
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          wd_cnt <= 16'd0;
          if (pick_valid) begin
            arb_grant         <= pick_grant;
            udp_send_data_len <= pick_len;
            udp_send_apply    <= 1'b1;
            state             <= ST_APPLY;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          wd_cnt <= wd_next;
          if (wd_hit) begin
            udp_send_apply <= 1'b0;
            timeout_pulse  <= 1'b1;
            req_send_over  <= arb_grant;
            state          <= ST_DONE;
          end else if (udp_send_data_en) begin
            udp_send_apply <= 1'b0;
            if (udp_send_over) begin
              req_send_over <= arb_grant;
              state         <= ST_DONE;
            end else begin
              state <= ST_SEND;
            end
          end else if ((req_apply & arb_grant) == 4'b0000) begin
            // Requester withdrew before the core started reading: silent abort.
            arb_grant      <= 4'b0000;
            udp_send_apply <= 1'b0;
            wd_cnt         <= 16'd0;
            state          <= ST_IDLE;
          end else begin
            state <= ST_APPLY;
          end
        end
        ST_SEND: begin
          wd_cnt <= wd_next;
          if (wd_hit) begin
            timeout_pulse <= 1'b1;
            req_send_over <= arb_grant;
            state         <= ST_DONE;
          end else if (udp_send_over) begin
            req_send_over <= arb_grant;
            state         <= ST_DONE;
          end else begin
            state <= ST_SEND;
          end
        end
        ST_DONE: begin
          last_grant <= onehot_to_idx(arb_grant);
          arb_grant  <= 4'b0000;
          wd_cnt     <= 16'd0;
          state      <= ST_IDLE;
        end
        default: begin
          arb_grant      <= 4'b0000;
          udp_send_apply <= 1'b0;
          wd_cnt         <= 16'd0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
